// File: rtl/switch_allocator.sv
// Credit-based wormhole switch allocator for a 5-port mesh router: one round-robin
// arbiter per output, head-to-tail output locking and per-output downstream credits.
module switch_allocator #(
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  req_valid,
  input  logic [24:0] req_dst,
  input  logic [4:0]  req_tail,
  input  logic [4:0]  credit_in,
  output logic [4:0]  grant,
  output logic [24:0] xbar_sel,
  output logic [4:0]  out_valid
);

  typedef enum logic {IDLE, LOCKED} lock_state_t;

  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  lock_state_t       state [5];
  logic [2:0]        owner [5];
  logic [2:0]        ptr   [5];
  logic [CW-1:0]     cred  [5];

  logic [4:0][4:0]   cand;
  logic [4:0][4:0]   sel;
  logic [4:0][2:0]   gidx;
  logic [4:0]        xfer;
  logic [4:0]        xfer_tail;
  logic [4:0]        dst_ok;

  function automatic logic onehot5(input logic [4:0] d);
    return (d != 5'd0) && ((d & (d - 5'd1)) == 5'd0);
  endfunction

  function automatic logic [2:0] enc5(input logic [4:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 5; i++)
      if (oh[i]) r = 3'(i);
    return r;
  endfunction

  // First candidate at or after p, wrapping 4 -> 0.
  function automatic logic [4:0] rr_pick(input logic [4:0] c, input logic [2:0] p);
    logic [4:0] r;
    logic       found;
    logic [2:0] idx;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      idx = 3'((int'(p) + k) % 5);
      if (!found && c[idx]) begin
        r[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    dst_ok    = '0;
    cand      = '0;
    sel       = '0;
    gidx      = '0;
    xfer      = '0;
    xfer_tail = '0;
    grant     = '0;
    xbar_sel  = '0;
    out_valid = '0;
    for (int i = 0; i < 5; i++)
      dst_ok[i] = req_valid[i] && onehot5(req_dst[5*i +: 5]);
    for (int o = 0; o < 5; o++) begin
      for (int i = 0; i < 5; i++)
        cand[o][i] = dst_ok[i] && req_dst[5*i + o];
      // A locked output serves only its owner; anyone else waits even if it idles.
      if (rst && cred[o] != '0) begin
        if (state[o] == LOCKED) begin
          if (cand[o][owner[o]]) sel[o][owner[o]] = 1'b1;
        end else begin
          sel[o] = rr_pick(cand[o], ptr[o]);
        end
      end
      gidx[o]            = enc5(sel[o]);
      xfer[o]            = |sel[o];
      xfer_tail[o]       = |(sel[o] & req_tail);
      xbar_sel[5*o +: 5] = sel[o];
      out_valid[o]       = xfer[o];
      grant              = grant | sel[o];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < 5; o++) begin
        state[o] <= IDLE;
        owner[o] <= '0;
        ptr[o]   <= '0;
        cred[o]  <= CRED_MAX;
      end
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (xfer[o]) begin
          if (xfer_tail[o]) begin
            state[o] <= IDLE;
            ptr[o]   <= (gidx[o] == 3'd4) ? 3'd0 : gidx[o] + 3'd1;
          end else begin
            state[o] <= LOCKED;
            owner[o] <= gidx[o];
          end
        end
        // Simultaneous transfer and returned credit cancel out.
        if (xfer[o] && !credit_in[o])
          cred[o] <= cred[o] - CW'(1);
        else if (!xfer[o] && credit_in[o] && cred[o] != CRED_MAX)
          cred[o] <= cred[o] + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: reset, round-robin, wormhole lock, credits,
// async reset mid-packet and malformed destinations.
module tb_switch_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req_valid;
  logic [24:0] req_dst;
  logic [4:0]  req_tail;
  logic [4:0]  credit_in;
  logic [4:0]  grant;
  logic [24:0] xbar_sel;
  logic [4:0]  out_valid;

  int vecs = 0;
  int miss = 0;

  switch_allocator #(.CREDITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_dst   (req_dst),
    .req_tail  (req_tail),
    .credit_in (credit_in),
    .grant     (grant),
    .xbar_sel  (xbar_sel),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_dst   = '0;
    req_tail  = '0;
  endtask

  task automatic set_req(input int i, input logic [4:0] dst, input logic tail);
    req_valid[i]       = 1'b1;
    req_dst[5*i +: 5]  = dst;
    req_tail[i]        = tail;
  endtask

  localparam logic [4:0] D_L = 5'b00001, D_N = 5'b00010, D_E = 5'b00100,
                         D_W = 5'b01000;

  logic [4:0] rr_exp [6];

  initial begin
    rst       = 1'b0;
    credit_in = '0;
    clear_req();

    // Outputs forced low while reset is asserted, even with a request pending.
    set_req(0, D_N, 1'b1);
    #2;
    chk("rst_grant", grant, 5'd0);
    chk("rst_out_valid", out_valid, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_req();
    #1;
    chk("idle_grant", grant, 5'd0);
    chk("idle_xbar", xbar_sel, 25'd0);
    chk("idle_out_valid", out_valid, 5'd0);

    // N sends a single flit to E.
    set_req(1, D_E, 1'b1);
    #1;
    chk("ne_grant", grant, 5'b00010);
    chk("ne_xbar_e", xbar_sel[14:10], 5'b00010);
    chk("ne_out_valid", out_valid, 5'b00100);
    tick();
    chk("ne_ptr_e", dut.ptr[2], 3'd2);
    clear_req();

    // Round robin L, N, S to W; credits returned every cycle.
    rr_exp = '{5'b00001, 5'b00010, 5'b10000, 5'b00001, 5'b00010, 5'b10000};
    set_req(0, D_W, 1'b1);
    set_req(1, D_W, 1'b1);
    set_req(4, D_W, 1'b1);
    credit_in = 5'b01000;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr_grant%0d", k), grant, rr_exp[k]);
      chk($sformatf("rr_xbar_w%0d", k), xbar_sel[19:15], rr_exp[k]);
      tick();
      if (k == 2) chk("rr_ptr_wrap", dut.ptr[3], 3'd0);
    end
    clear_req();
    credit_in = '0;
    tick();

    // Wormhole: E 3-flit packet to L, N joins from the body flit.
    credit_in = 5'b00001;
    set_req(2, D_L, 1'b0);
    #1; chk("wh_head", grant, 5'b00100);
    tick();
    set_req(1, D_L, 1'b1);
    #1; chk("wh_body", grant, 5'b00100);
    tick();
    set_req(2, D_L, 1'b1);
    #1; chk("wh_tail", grant, 5'b00100);
    tick();
    req_valid[2] = 1'b0;
    #1; chk("wh_next_n", grant, 5'b00010);
    tick();
    // Second packet with a bubble; ptr[L] now favours E.
    set_req(2, D_L, 1'b0);
    #1; chk("wb_head", grant, 5'b00100);
    tick();
    req_valid[2] = 1'b0;
    #1;
    chk("wb_bubble_grant", grant, 5'd0);
    chk("wb_bubble_outv", out_valid, 5'd0);
    tick();
    set_req(2, D_L, 1'b0);
    #1; chk("wb_body", grant, 5'b00100);
    tick();
    set_req(2, D_L, 1'b1);
    #1; chk("wb_tail", grant, 5'b00100);
    tick();
    req_valid[2] = 1'b0;
    #1; chk("wb_next_n", grant, 5'b00010);
    tick();
    clear_req();
    tick();
    chk("cred_l_sat", dut.cred[0], 3'd4);
    credit_in = '0;

    // Credit exhaustion: L streams to N.
    set_req(0, D_N, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1; chk($sformatf("cx_grant%0d", k), grant, 5'b00001);
      tick();
    end
    #1; chk("cx_stall", grant, 5'd0);
    tick();
    credit_in = 5'b00010;
    #1; chk("cx_pulse_cycle", grant, 5'd0);
    tick();
    credit_in = '0;
    #1; chk("cx_after_pulse", grant, 5'b00001);
    tick();
    #1; chk("cx_stall_again", grant, 5'd0);
    clear_req();

    // Build cred[N]=2, then transfer and credit together.
    credit_in = 5'b00010;
    tick();
    tick();
    chk("sim_cred_pre", dut.cred[1], 3'd2);
    set_req(0, D_N, 1'b1);
    #1; chk("sim_grant", grant, 5'b00001);
    tick();
    chk("sim_cred_post", dut.cred[1], 3'd2);
    credit_in = '0;
    clear_req();

    // S locks E, then reset mid-packet.
    set_req(4, D_E, 1'b0);
    #1; chk("rm_head", grant, 5'b10000);
    tick();
    req_valid[4] = 1'b0;
    set_req(1, D_E, 1'b1);
    #1; chk("rm_locked_out", grant, 5'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("rm_in_reset", out_valid, 5'd0);
    chk("rm_cred_e", dut.cred[2], 3'd4);
    tick();
    rst = 1'b1;
    #1; chk("rm_unlocked", grant, 5'b00010);
    tick();
    clear_req();

    // Malformed destinations are never candidates.
    set_req(0, 5'b00011, 1'b1);
    set_req(3, 5'b00000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bad_dst_grant%0d", k), grant, 5'd0);
      chk($sformatf("bad_dst_outv%0d", k), out_valid, 5'd0);
      tick();
    end
    clear_req();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Credit-based wormhole switch allocator for the 5-port (L, N, E, W, S) mesh router. It arbitrates the five input ports' requests for the five output ports, one round-robin arbiter per output. It holds each output locked to one input from head flit to tail flit, and tracks downstream buffer credits per output. It drives the crossbar select and the per-input grants that pop the input FIFOs.

## Interface
Parameters:
- CREDITS, 4: downstream input-buffer depth; initial and maximum credit count per output.
- CW, $clog2(CREDITS+1): credit counter width.

Ports (port index for inputs and outputs: 0=L, 1=N, 2=E, 3=W, 4=S):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-low.
- req_valid  in  5  input i has a flit at its FIFO head.
- req_dst  in  25  bits [5i+4:5i] are the one-hot destination output of input i's flit.
- req_tail  in  5  input i's head flit is a tail; a single-flit packet has head and tail both set.
- credit_in  in  5  one-cycle pulse: downstream of output o freed one slot.
- grant  out  5  input i's flit crosses the crossbar this cycle, and its FIFO pops.
- xbar_sel  out  25  bits [5o+4:5o] are the one-hot input selected for output o, or 0 when idle.
- out_valid  out  5  output o carries a valid flit this cycle.

## Operation
- Each output o has the following state:
  - lock FSM: IDLE, or LOCKED with owner[o] in 0..4.
  - rr pointer ptr[o] in 0..4.
  - credit counter cred[o].
- Candidate for output o: any input i with req_valid[i]=1 and req_dst[5i+o]=1.
- If req_dst for input i is zero or multi-hot, input i is never a candidate.
- IDLE behaviour:
  - If cred[o]>0, grant the first candidate searching ptr[o], ptr[o]+1, … mod 5 (4 wraps to 0).
  - If the granted flit has req_tail=0, move to LOCKED with owner=i.
  - If the granted flit has req_tail=1, stay IDLE.
- LOCKED behaviour:
  - Only the owner can be granted.
  - The owner is granted when it is a candidate and cred[o]>0.
  - A granted tail flit returns the FSM to IDLE.
  - If the owner drops req_valid, or credits are 0, output o idles (bubble). The lock holds and no other input is served.
- Pointer: on every tail transfer from input i, ptr[o] ← (i+1) mod 5. Non-tail transfers leave ptr[o] unchanged.
- Outputs on a transfer (same cycle):
  - grant[i]=1.
  - xbar_sel[5o+i]=1.
  - out_valid[o]=1.
  - Every other select bit for output o is 0.
- Each input targets one output, so an input never receives two grants.
- Credits:
  - A transfer only: cred−1.
  - credit_in only: cred+1.
  - Both in the same cycle: cred unchanged.
  - credit_in while cred==CREDITS with no transfer is ignored; cred saturates at CREDITS.
  - A transfer at cred==0 is impossible by construction.

## Timing
- grant, xbar_sel and out_valid are combinational from the current state and the inputs (zero-cycle grant).
- Lock state, ptr and cred update on the rising clk edge after a transfer.
- credit_in in cycle t takes effect for grants in cycle t+1.
- A new packet can take an output in the cycle right after the previous tail left it.
- Reset (rst=0, asynchronous, any time including mid-packet):
  - All FSMs go to IDLE, all locks are released.
  - ptr=0, so L has highest priority.
  - cred=CREDITS.
- Outputs follow from the state combinationally. With req_valid=0 they are grant=0, xbar_sel=0, out_valid=0.
- While rst is low, grant, xbar_sel and out_valid are forced to 0.
- Full sustained throughput is one flit per output per cycle while credits last.

## Test plan
- Reset state:
  - Stimulus: release rst, then req_valid=0.
  - Required: all outputs 0.
  - Then N (1) sends a single-flit packet to E: same cycle grant=00010, xbar_sel[14:10]=00010, out_valid=00100. Next cycle ptr[E]=2.
- Round-robin:
  - Stimulus: L, N and S each send back-to-back single-flit packets to W from reset.
  - Required: grant order L, N, S, L, N, S.
  - Required: ptr[W] wraps 4→0 after S is served.
- Wormhole lock:
  - Stimulus: E sends a 3-flit packet (head, body, tail) to L, while N requests L continuously.
  - Required: E is granted 3 consecutive cycles, then N on cycle 4.
  - Required: when E drops req_valid for 1 cycle mid-packet, out_valid[L]=0 that cycle and N is not granted.
- Credit exhaustion:
  - Stimulus: CREDITS=4, L streams to N with no credit_in.
  - Required: 4 grants, then a stall.
  - Then credit_in[N] pulses at cycle t: exactly one grant at t+1.
- Simultaneous credit and transfer: at cred=2, a transfer plus credit_in in the same cycle gives cred=2 next cycle.
- Reset mid-packet plus malformed dst:
  - Stimulus: assert rst mid-packet.
  - Required: the lock is cleared and cred=CREDITS.
  - Stimulus: req_dst=00011 (multi-hot).
  - Required: never granted.
